muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with built-in HI/LO result registers. It replaces the separate mult, div, HIGH/LOW muxes and HIGH/LOW registers in the CPU datapath. The unit takes operands from the A/B registers and a 2-bit operation code. It runs a start/busy/done handshake, and its HI/LO outputs feed the MemToReg mux directly for MFHI/MFLO. MTHI/MTLO are supported through a direct write port.

## Interface
- WIDTH, 32, operand and HI/LO width; any value ≥ 4.
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
- a  in  WIDTH  multiplicand or dividend; sampled with start.
- b  in  WIDTH  multiplier or divisor; sampled with start.
- wr_hi  in  1  MTHI: load wr_data into hi.
- wr_lo  in  1  MTLO: load wr_data into lo.
- wr_data  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: operation finished.
- div_zero  out  1  one-cycle pulse with done: DIV/DIVU with b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal counter and accumulators cleared.
- States and transitions:
  - IDLE.
    - start=1 and op is a divide with b==0: stay IDLE; set done=1 and div_zero=1 for the next cycle; hi/lo unchanged.
    - start=1 otherwise: capture |a|, |b| and the result-sign flags; signed ops only, unsigned ops take operands raw. Clear counter, go to RUN.
  - RUN: exactly WIDTH iterations, one per cycle.
    - Multiply: shift-add, 2·WIDTH-bit unsigned product of the magnitudes.
    - Divide: restoring, one quotient bit per cycle, unsigned on the magnitudes.
    - Go to FIX after iteration WIDTH.
  - FIX: apply sign correction, write hi/lo, set done=1 for the next cycle, return to IDLE.
- done and div_zero are high for exactly one cycle. done is high while the unit is already in IDLE.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product. MULT is two's-complement.
  - DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIV of the most negative value by −1: lo = most negative value (wraps), hi = 0. No flag is raised.
  - DIVU: unsigned quotient and remainder.
  - The magnitude of the most negative signed operand must be handled as an unsigned WIDTH-bit value. No extra width is lost.
- MTHI/MTLO:
  - In IDLE (including the done cycle), wr_hi/wr_lo update hi/lo at the next edge.
  - If issued together with start, the write still takes effect; the later operation result then overwrites it.
  - Ignored while busy=1.
- start while busy=1: ignored. No queuing, and no effect on the running operation.
- op and operand changes after the start cycle: no effect.
- Reset mid-operation: abort at the next edge. All outputs return to reset values, no done pulse, and hi/lo are cleared.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Normal operation:
  - busy=1 in cycles 1 … WIDTH+1.
  - done=1 and new hi/lo visible in cycle WIDTH+2. For WIDTH=32 that is cycle 34.
  - Latency is identical for all four ops and all operand values. There is no early termination.
- Divide-by-zero: done=1 and div_zero=1 in cycle 1; busy never asserts.
- Back-to-back: a new start may be asserted in the done cycle, giving a throughput of one operation per WIDTH+2 cycles.
- hi/lo are registered and change only:
  - at the FIX edge,
  - at an accepted wr_hi/wr_lo edge,
  - at reset.
- They are stable at all other times, including during RUN.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULT, WIDTH=32: a=0xFFFFFFFD (−3), b=7 → cycle 34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high in cycles 1–33 only.
- MULTU: a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then back-to-back MULT in the done cycle: a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- DIV: a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU: a=7, b=2 → lo=3, hi=1. DIV: a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide-by-zero: preload hi=0x1234, lo=0x5678 via wr_hi/wr_lo, then DIV with b=0 → cycle 1: done=1, div_zero=1, busy=0 throughout, hi/lo unchanged.
- Contention: start MULT 5×6, pulse start with op=DIV in cycle 5, pulse wr_hi in cycle 7 → both ignored; result hi=0, lo=30 in cycle 34.
- Reset and width: start DIVU, assert reset in cycle 10 → cycle 11: busy=0, done=0, hi=lo=0, and no done follows. Rerun with WIDTH=8: MULT 0x80×0x80 → hi=0x40, lo=0x00, done in cycle 10.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Handshake, operand and HI/LO result bundle for muldiv_unit.
// The CPU datapath is the master; the unit itself is the slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO port.
// Fixed WIDTH+2 cycle latency: shift-add multiply or restoring divide on magnitudes.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clock,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               div_zero_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        a_neg     = ~bus.op[0] & bus.a[WIDTH-1];
        b_neg     = ~bus.op[0] & bus.b[WIDTH-1];
        abs_a     = a_neg ? -bus.a : bus.a;
        abs_b     = b_neg ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
        step_next = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            step_next = {(div_trial[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : div_trial[WIDTH-1:0]),
                         acc[WIDTH-2:0], ~div_trial[WIDTH]};
        end
        fix_hi = '0;
        fix_lo = '0;
        if (is_div) begin
            fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            {fix_hi, fix_lo} = neg_lo ? -acc : acc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            is_div     <= 1'b0;
            neg_lo     <= 1'b0;
            neg_hi     <= 1'b0;
            mag_b      <= '0;
            acc        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_hi) hi_q <= bus.wr_data;
                    if (bus.wr_lo) lo_q <= bus.wr_data;
                    if (bus.start) begin
                        if (bus.op[1] && bus.b == '0) begin
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                        end else begin
                            is_div <= bus.op[1];
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                            mag_b  <= abs_b;
                            acc    <= {{WIDTH{1'b0}}, abs_a};
                            count  <= '0;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc   <= step_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of MULT/DIV vectors at WIDTH=32 plus
// hand sequences for divide-by-zero, contention, reset abort, back-to-back and WIDTH=8.
module tb_muldiv_unit;
    localparam int W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut  (.clock(clock), .reset(reset), .bus(bus));
    muldiv_unit #(.WIDTH(8))  dut8 (.clock(clock), .reset(reset), .bus(bus8));

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Called in cycle 0; returns in the done cycle (W+2). Operands are scrambled
    // after the start cycle to show they are no longer sampled.
    task automatic finish_op(input string name, input logic [31:0] eh, input logic [31:0] el);
        logic        run_ok;
        logic [31:0] h0;
        logic [31:0] l0;
        run_ok = 1'b1;
        h0 = bus.hi;
        l0 = bus.lo;
        for (int c = 1; c <= W + 1; c++) begin
            tick();
            if (c == 1) begin
                bus.start = 1'b0;
                bus.op    = ~bus.op;
                bus.a     = ~bus.a;
                bus.b     = ~bus.b;
            end
            if (!(bus.busy === 1'b1 && bus.done === 1'b0 && bus.hi === h0 && bus.lo === l0))
                run_ok = 1'b0;
        end
        check({name, " run window"}, 64'(run_ok), 64'd1);
        tick();
        check({name, " done"}, {61'd0, bus.done, bus.busy, bus.div_zero}, 64'b100);
        check({name, " hi"}, 64'(bus.hi), 64'(eh));
        check({name, " lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        vecs[0] = '{"mult -3x7",       OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{"mult min x -1",   OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[2] = '{"multu 123x456",   OP_MULTU, 32'd123,      32'd456,      32'h00000000, 32'd56088};
        vecs[3] = '{"div -7/2",        OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{"div 7/-2",        OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[5] = '{"divu 7/2",        OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003};
        vecs[6] = '{"div min/-1",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7] = '{"divu max/16",     OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[8] = '{"div 100/7",       OP_DIV,   32'd100,      32'd7,        32'h00000002, 32'h0000000E};

        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
        bus8.start = 1'b0; bus8.op = 2'b00; bus8.a = '0; bus8.b = '0;
        bus8.wr_hi = 1'b0; bus8.wr_lo = 1'b0; bus8.wr_data = '0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);

        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            finish_op(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo);
        end
        tick();
        check("done one-cycle", {62'd0, bus.done, bus.busy}, 64'd0);

        // Back-to-back: second start issued in the done cycle of the first.
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("multu max^2", 32'hFFFFFFFE, 32'h00000001);
        start_op(OP_MULT, 32'h80000000, 32'h80000000);
        finish_op("b2b mult min^2", 32'h40000000, 32'h00000000);

        // MTHI/MTLO preload, then divide by zero leaves hi/lo untouched.
        tick();
        bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
        tick();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'h5678;
        tick();
        bus.wr_lo = 1'b0;
        check("mthi/mtlo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
        start_op(OP_DIV, 32'd5, 32'd0);
        tick();
        bus.start = 1'b0;
        check("divz cycle1", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'b011);
        check("divz hi/lo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
        tick();
        check("divz cycle2", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'b000);

        // Contention: start pulse in cycle 5 and wr_hi in cycle 7 are both ignored.
        start_op(OP_MULT, 32'd5, 32'd6);
        for (int c = 1; c <= W + 2; c++) begin
            tick();
            bus.start = (c == 5);
            bus.op    = (c == 5) ? OP_DIV : OP_MULT;
            bus.b     = (c == 5) ? 32'd0 : 32'd6;
            bus.wr_hi = (c == 7);
            bus.wr_data = 32'hDEAD;
            if (c == 8) check("busy wr_hi ignored", 64'(bus.hi), 64'h1234);
            if (c == W + 1) check("contention no early done", {62'd0, bus.busy, bus.done}, 64'b10);
        end
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        check("contention done", {62'd0, bus.done, bus.div_zero}, 64'b10);
        check("contention hi/lo", {bus.hi, bus.lo}, {32'd0, 32'd30});

        // Reset in cycle 10 aborts the divide with no done pulse afterwards.
        tick();
        start_op(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c <= 10; c++) begin
            tick();
            bus.start = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        check("abort hi/lo", {bus.hi, bus.lo}, 64'd0);
        begin
            logic quiet;
            quiet = 1'b1;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
            end
            check("abort no done", 64'(quiet), 64'd1);
        end

        // WIDTH=8: done in cycle 10, second op issued back-to-back.
        for (int k = 0; k < 2; k++) begin
            logic run_ok;
            run_ok = 1'b1;
            bus8.start = 1'b1;
            bus8.op    = (k == 0) ? OP_MULT : OP_DIV;
            bus8.a     = (k == 0) ? 8'h80 : 8'hF9;
            bus8.b     = (k == 0) ? 8'h80 : 8'h02;
            for (int c = 1; c <= 9; c++) begin
                tick();
                bus8.start = 1'b0;
                if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) run_ok = 1'b0;
            end
            check("w8 run window", 64'(run_ok), 64'd1);
            tick();
            check("w8 done", {62'd0, bus8.done, bus8.busy}, 64'b10);
            check("w8 hi/lo", {48'd0, bus8.hi, bus8.lo}, (k == 0) ? 64'h4000 : 64'hFFFD);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
